// File: rtl/decoder_pkg.sv
// Shared types and decode function for the decode stage.
// Optional field: illegal flag, present with DECODER_ILLEGAL_OP_EN.
package decoder_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_MEM  = 3'b001;
  localparam logic [2:0] SEL_ALU  = 3'b010;
  localparam logic [2:0] SEL_ACC  = 3'b011;
  localparam logic [2:0] SEL_IMM  = 3'b100;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [2:0]          sel;
    logic                acc;
    logic                mode;
`ifdef DECODER_ILLEGAL_OP_EN
    logic                illegal;
`endif
  } dec_t;

  // Returns {sel[2:0], acc}
  function automatic logic [3:0] decode_op(
    input logic [OPCODE_W-1:0] op
  );
    logic a, b, c, d, e;
    logic s2, s1, s0, ac;
    {a, b, c, d, e} = op;
    s2 = ~a & ~b & ~c & ~d & e;
    s1 = (~a & ~b & ~c & d & e)
       | (~a & b & c);
    s0 = (a & ~b) | (~b & ~c & d);
    ac = (~a & b & ~c & ~d)
       | (~b & ~c & d & e)
       | (a & ~b);
    return {s2, s1, s0, ac};
  endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Two-entry skid buffer: OUT register plus SKD register, FIFO order.
// Ports: clk_i, rst_ni, flush_i, in_* / out_* valid/ready/data.
module decoder_skid_buf
  import decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  state_e       state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skd_q, skd_d;
  logic         in_fire, out_fire;

  // Ready derives from state only; no path from out_ready_i.
  assign in_ready_o  = (state_q != SKID);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = out_q;

  // A flush cycle never accepts, even though ready is high.
  assign in_fire  = in_valid_i & in_ready_o & ~flush_i;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skd_d   = skd_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          out_d   = in_data_i;
          state_d = FULL;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          out_d = in_data_i;
        end else if (in_fire) begin
          skd_d   = in_data_i;
          state_d = SKID;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_fire) begin
          out_d   = skd_q;
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skd_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skd_q   <= skd_d;
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Flow-controlled decode stage: opcode -> selector + acc flag.
// Ports: clock/reset, in handshake+payload, flush, out handshake+decoded
// payload; IllegalOpOutput only with DECODER_ILLEGAL_OP_EN.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int          OPERAND_W = 16,
  parameter logic [31:0] VALID_OPS = 32'hFFFF_FFFF
) (
  input  logic                 ClockInput,
  input  logic                 ResetNInput,
  input  logic                 InValidInput,
  output logic                 InReadyOutput,
  input  logic [OPCODE_W-1:0]  OpecodeInput,
  input  logic                 AddressingModeInput,
  input  logic [OPERAND_W-1:0] OperandInput,
  input  logic                 FlushInput,
  output logic                 OutValidOutput,
  input  logic                 OutReadyInput,
  output logic [OPCODE_W-1:0]  OpecodeOutput,
  output logic [2:0]           OutputSelectorOutput,
  output logic                 AccReadFlagOutput,
  output logic                 AddressingModeOutput,
  output logic [OPERAND_W-1:0] OperandOutput
`ifdef DECODER_ILLEGAL_OP_EN
  ,
  output logic                 IllegalOpOutput
`endif
);

  localparam int W = $bits(dec_t) + OPERAND_W;

  logic [3:0]   dec;
  dec_t         in_dec, out_dec;
  logic [W-1:0] in_data, out_data;

  assign dec = decode_op(OpecodeInput);

  always_comb begin
    in_dec        = '0;
    in_dec.opcode = OpecodeInput;
    in_dec.sel    = dec[3:1];
    in_dec.acc    = dec[0];
    in_dec.mode   = AddressingModeInput;
`ifdef DECODER_ILLEGAL_OP_EN
    in_dec.illegal = ~VALID_OPS[OpecodeInput];
    if (in_dec.illegal) begin
      in_dec.sel = SEL_NONE;
      in_dec.acc = 1'b0;
    end
`endif
  end

`ifndef DECODER_ILLEGAL_OP_EN
  logic unused_valid_ops;
  assign unused_valid_ops = ^VALID_OPS;
`endif

  assign in_data = {in_dec, OperandInput};

  decoder_skid_buf #(
    .W (W)
  ) u_skid (
    .clk_i       (ClockInput),
    .rst_ni      (ResetNInput),
    .flush_i     (FlushInput),
    .in_valid_i  (InValidInput),
    .in_ready_o  (InReadyOutput),
    .in_data_i   (in_data),
    .out_valid_o (OutValidOutput),
    .out_ready_i (OutReadyInput),
    .out_data_o  (out_data)
  );

  assign {out_dec, OperandOutput} = out_data;

  assign OpecodeOutput        = out_dec.opcode;
  assign OutputSelectorOutput = out_dec.sel;
  assign AccReadFlagOutput    = out_dec.acc;
  assign AddressingModeOutput = out_dec.mode;
`ifdef DECODER_ILLEGAL_OP_EN
  assign IllegalOpOutput      = out_dec.illegal;
`endif

endmodule
